elevator_shaft_model: RTL and testbench



---
 rtl/elevator_pkg.sv | 19 +
 rtl/elevator_door_timer.sv | 34 +++
 rtl/elevator_shaft_model.sv | 151 +++++++++++++++
 tb/tb_elevator_shaft_model.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/elevator_pkg.sv
// Shared types and helpers for the elevator shaft plant model.
// Holds the shaft state encoding and the position-width helper.
package elevator_pkg;

    typedef enum logic [2:0] {
        IDLE,
        MOVE_UP,
        MOVE_DOWN,
        DOOR,
        FAULT
    } shaft_state_t;

    localparam int NUM_FLOORS = 4;

    function automatic int pos_width(input int tpf);
        return $clog2((NUM_FLOORS - 1) * tpf + 1);
    endfunction

endpackage

// File: rtl/elevator_door_timer.sv
// Door travel timer: saturating up/down counter 0..DOOR_TICKS.
// Counts only while enabled; open when full, closed when empty.
module elevator_door_timer #(
    parameter int DOOR_TICKS = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic open_cmd,
    output logic door_open,
    output logic door_closed
);

    localparam int CW = $clog2(DOOR_TICKS + 1);
    localparam logic [CW-1:0] FULL = CW'(DOOR_TICKS);

    logic [CW-1:0] cnt;

    // Door position moves one step per enabled edge toward the command.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (en) begin
            if (open_cmd && cnt != FULL)
                cnt <= cnt + CW'(1);
            else if (!open_cmd && cnt != '0)
                cnt <= cnt - CW'(1);
        end
    end

    assign door_open   = (cnt == FULL);
    assign door_closed = (cnt == '0);

endmodule

// File: rtl/elevator_shaft_model.sv
// Behavioural 4-floor elevator shaft: car position, sensors, door.
// Illegal controller commands latch a sticky fault and freeze the plant.
module elevator_shaft_model
    import elevator_pkg::*;
#(
    parameter int TICKS_PER_FLOOR = 8,
    parameter int DOOR_TICKS      = 4,
    parameter int START_FLOOR     = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       up,
    input  logic       down,
    input  logic       stop,
    input  logic       opendoor,
    output logic       S1,
    output logic       S2,
    output logic       S3,
    output logic       S4,
    output logic [1:0] floor,
    output logic       moving,
    output logic       door_open,
    output logic       fault
);

    localparam int PW = pos_width(TICKS_PER_FLOOR);
    localparam logic [PW-1:0] P1 = PW'(TICKS_PER_FLOOR);
    localparam logic [PW-1:0] P2 = PW'(2 * TICKS_PER_FLOOR);
    localparam logic [PW-1:0] P3 = PW'(3 * TICKS_PER_FLOOR);
    localparam logic [PW-1:0] P0 = PW'(START_FLOOR * TICKS_PER_FLOOR);

    shaft_state_t  state, state_nxt;
    logic [PW-1:0] pos, pos_nxt;
    logic [1:0]    floor_nxt;
    logic          legal, aligned, fault_evt;
    logic          door_en, door_closed;

    assign S1 = (pos == '0);
    assign S2 = (pos == P1);
    assign S3 = (pos == P2);
    assign S4 = (pos == P3);

    assign aligned = S1 | S2 | S3 | S4;
    assign legal   = ({up, down, stop} inside {3'b100, 3'b010, 3'b001});

    assign fault_evt = (state != FAULT) &&
        (!legal ||
         (up && pos == P3) ||
         (down && pos == '0) ||
         (opendoor && !aligned) ||
         ((up || down) && opendoor && !door_closed));

    elevator_door_timer #(
        .DOOR_TICKS (DOOR_TICKS)
    ) u_door (
        .clk         (clk),
        .reset       (reset),
        .en          (door_en),
        .open_cmd    (opendoor),
        .door_open   (door_open),
        .door_closed (door_closed)
    );

    // Next state, next position and door enable; faults override motion.
    always_comb begin
        state_nxt = state;
        pos_nxt   = pos;
        door_en   = 1'b0;
        if (fault_evt) begin
            state_nxt = FAULT;
        end else begin
            unique case (state)
                IDLE: begin
                    if (up) begin
                        state_nxt = MOVE_UP;
                        pos_nxt   = pos + PW'(1);
                    end else if (down) begin
                        state_nxt = MOVE_DOWN;
                        pos_nxt   = pos - PW'(1);
                    end else if (opendoor) begin
                        state_nxt = DOOR;
                        door_en   = 1'b1;
                    end
                end
                MOVE_UP: begin
                    if (up) begin
                        pos_nxt = pos + PW'(1);
                    end else if (down) begin
                        state_nxt = MOVE_DOWN;
                        pos_nxt   = pos - PW'(1);
                    end else if (aligned) begin
                        state_nxt = IDLE;
                    end
                end
                MOVE_DOWN: begin
                    if (down) begin
                        pos_nxt = pos - PW'(1);
                    end else if (up) begin
                        state_nxt = MOVE_UP;
                        pos_nxt   = pos + PW'(1);
                    end else if (aligned) begin
                        state_nxt = IDLE;
                    end
                end
                DOOR: begin
                    door_en = 1'b1;
                    if (door_closed && !opendoor)
                        state_nxt = IDLE;
                end
                FAULT: begin
                    state_nxt = FAULT;
                end
                default: begin
                    state_nxt = FAULT;
                end
            endcase
        end
    end

    // Floor index follows the position only when it lands on a floor.
    always_comb begin
        floor_nxt = floor;
        if (pos_nxt == '0)
            floor_nxt = 2'd0;
        else if (pos_nxt == P1)
            floor_nxt = 2'd1;
        else if (pos_nxt == P2)
            floor_nxt = 2'd2;
        else if (pos_nxt == P3)
            floor_nxt = 2'd3;
    end

    // Plant state registers with sticky fault flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            pos    <= P0;
            floor  <= 2'(START_FLOOR);
            moving <= 1'b0;
            fault  <= 1'b0;
        end else begin
            state  <= state_nxt;
            pos    <= pos_nxt;
            floor  <= floor_nxt;
            moving <= (pos_nxt != pos);
            if (fault_evt)
                fault <= 1'b1;
        end
    end

endmodule

// File: tb/tb_elevator_shaft_model.sv
// Scoreboard bench for the elevator shaft plant.
// Expected sensor/floor/status words queued on drive, popped on sample.
module tb_elevator_shaft_model;

    localparam int TPF = 8;

    typedef struct {
        string      tag;
        logic [8:0] val;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       up = 1'b0;
    logic       down = 1'b0;
    logic       stop = 1'b1;
    logic       opendoor = 1'b0;
    logic       S1, S2, S3, S4;
    logic [1:0] floor;
    logic       moving, door_open, fault;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   exp_fl = 0;

    wire [8:0] obs = {S4, S3, S2, S1, floor, moving, door_open, fault};

    elevator_shaft_model #(
        .TICKS_PER_FLOOR (TPF),
        .DOOR_TICKS      (4),
        .START_FLOOR     (0)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .up        (up),
        .down      (down),
        .stop      (stop),
        .opendoor  (opendoor),
        .S1        (S1),
        .S2        (S2),
        .S3        (S3),
        .S4        (S4),
        .floor     (floor),
        .moving    (moving),
        .door_open (door_open),
        .fault     (fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [8:0] got,
                       input logic [8:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b (S4..S1,floor,mv,door,fault)",
                     tag, got, exp);
        end
    endtask

    function automatic logic [8:0] mk(input int p, input int fl,
                                      input bit mv, input bit dop,
                                      input bit flt);
        logic [3:0] s;
        s[0] = (p == 0);
        s[1] = (p == TPF);
        s[2] = (p == 2 * TPF);
        s[3] = (p == 3 * TPF);
        return {s, 2'(fl), mv, dop, flt};
    endfunction

    task automatic push_exp(input string tag, input int p, input bit mv,
                            input bit dop, input bit flt);
        exp_t e;
        if (p % TPF == 0)
            exp_fl = p / TPF;
        e.tag = tag;
        e.val = mk(p, exp_fl, mv, dop, flt);
        sb.push_back(e);
    endtask

    task automatic pop_chk();
        exp_t e;
        if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL sb_empty: got no entry expected one");
        end else begin
            e = sb.pop_front();
            chk(e.tag, obs, e.val);
        end
    endtask

    task automatic step(input string tag, input bit u, input bit d,
                        input bit s, input bit o, input int p,
                        input bit mv, input bit dop, input bit flt);
        up = u;
        down = d;
        stop = s;
        opendoor = o;
        push_exp(tag, p, mv, dop, flt);
        @(posedge clk);
        #1;
        pop_chk();
    endtask

    task automatic do_reset(input string tag);
        up = 1'b0;
        down = 1'b0;
        stop = 1'b1;
        opendoor = 1'b0;
        reset = 1'b0;
        #1;
        push_exp(tag, 0, 0, 0, 0);
        pop_chk();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1;
        do_reset("reset_state");

        for (int i = 1; i <= 16; i++)
            step("travel_up", 1, 0, 0, 0, i, 1, 0, 0);

        step("stop_at_s3", 0, 0, 1, 0, 16, 0, 0, 0);
        for (int i = 1; i <= 4; i++)
            step("door_opening", 0, 0, 1, 1, 16, 0, i == 4, 0);
        for (int i = 1; i <= 4; i++)
            step("door_closing", 1, 0, 0, 0, 16, 0, 0, 0);
        step("door_to_idle", 1, 0, 0, 0, 16, 0, 0, 0);
        for (int i = 1; i <= 8; i++)
            step("travel_after_door", 1, 0, 0, 0, 16 + i, 1, 0, 0);
        step("overtravel", 1, 0, 0, 0, 24, 0, 0, 1);
        step("fault_sticky", 0, 0, 1, 0, 24, 0, 0, 1);

        do_reset("reset_after_fault");
        step("illegal_up_down", 1, 1, 0, 0, 0, 0, 0, 1);

        do_reset("reset_clear");
        for (int i = 1; i <= 3; i++)
            step("short_up", 1, 0, 0, 0, i, 1, 0, 0);
        for (int i = 1; i <= 3; i++)
            step("reverse_down", 0, 1, 0, 0, 3 - i, 1, 0, 0);
        for (int i = 1; i <= 13; i++)
            step("up_to_13", 1, 0, 0, 0, i, 1, 0, 0);
        do_reset("async_reset_mid");

        for (int i = 1; i <= 5; i++)
            step("up_to_5", 1, 0, 0, 0, i, 1, 0, 0);
        step("hold_mid_span", 0, 0, 1, 0, 5, 0, 0, 0);
        step("door_off_floor", 0, 0, 1, 1, 5, 0, 0, 1);
        step("frozen_up", 1, 0, 0, 0, 5, 0, 0, 1);
        step("frozen_door", 0, 0, 1, 1, 5, 0, 0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
